alu_mdu_control: RTL and testbench

ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

---
 rtl/alu_mdu_control_if.sv | 42 ++++
 rtl/alu_mdu_control.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_mdu_control.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_control_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_mdu_control_if
// Description : Bundles the EX-stage connections of alu_mdu_control.
//               Inputs  : i_valid, i_function, i_alu_op, i_rs_data, i_rt_data
//               Outputs : o_alu_op, o_stall, o_mdu_sel, o_mdu_result,
//                         o_hi, o_lo, o_div_by_zero
//               The slave modport belongs to the control block and the
//               master modport to the pipeline that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_mdu_control_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_FUNCTION = 6,
  parameter int NB_ALU_OP   = 3,
  parameter int NB_OP_ALU   = 4
);
  logic                   i_valid;
  logic [NB_FUNCTION-1:0] i_function;
  logic [NB_ALU_OP-1:0]   i_alu_op;
  logic [NB_DATA-1:0]     i_rs_data;
  logic [NB_DATA-1:0]     i_rt_data;
  logic [NB_OP_ALU-1:0]   o_alu_op;
  logic                   o_stall;
  logic                   o_mdu_sel;
  logic [NB_DATA-1:0]     o_mdu_result;
  logic [NB_DATA-1:0]     o_hi;
  logic [NB_DATA-1:0]     o_lo;
  logic                   o_div_by_zero;

  modport slave (
    input  i_valid, i_function, i_alu_op, i_rs_data, i_rt_data,
    output o_alu_op, o_stall, o_mdu_sel, o_mdu_result, o_hi, o_lo, o_div_by_zero
  );

  modport master (
    output i_valid, i_function, i_alu_op, i_rs_data, i_rt_data,
    input  o_alu_op, o_stall, o_mdu_sel, o_mdu_result, o_hi, o_lo, o_div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_mdu_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_mdu_control
// Description : EX-stage ALU operation decoder plus an iterative multiply /
//               divide unit with architectural HI/LO registers.
//               i_clock / i_reset : clock, synchronous active-high reset
//               bus (slave)       : instruction fields and operands in;
//                                   ALU op, stall, MFHI/MFLO result mux,
//                                   HI/LO and divide-by-zero flag out.
//               Mul/div latency: one start cycle plus NB_DATA iteration
//               cycles (all stalled), then one DONE cycle writing HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_control #(
  parameter int NB_DATA     = 32,
  parameter int NB_FUNCTION = 6,
  parameter int NB_ALU_OP   = 3,
  parameter int NB_OP_ALU   = 4
) (
  input  wire logic           i_clock,
  input  wire logic           i_reset,
  alu_mdu_control_if.slave    bus
);

  localparam int NB_CNT = $clog2(NB_DATA + 1);

  // ALUop encodings coming from the main decoder
  localparam logic [NB_ALU_OP-1:0] ALUOP_RTYPE = NB_ALU_OP'(0);
  localparam logic [NB_ALU_OP-1:0] ALUOP_ADD   = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] ALUOP_AND   = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] ALUOP_OR    = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] ALUOP_XOR   = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] ALUOP_LUI   = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] ALUOP_SLT   = NB_ALU_OP'(6);

  // R-type function codes
  localparam logic [NB_FUNCTION-1:0] FN_SLL   = NB_FUNCTION'('h00);
  localparam logic [NB_FUNCTION-1:0] FN_SRL   = NB_FUNCTION'('h02);
  localparam logic [NB_FUNCTION-1:0] FN_SRA   = NB_FUNCTION'('h03);
  localparam logic [NB_FUNCTION-1:0] FN_SLLV  = NB_FUNCTION'('h04);
  localparam logic [NB_FUNCTION-1:0] FN_SRLV  = NB_FUNCTION'('h06);
  localparam logic [NB_FUNCTION-1:0] FN_SRAV  = NB_FUNCTION'('h07);
  localparam logic [NB_FUNCTION-1:0] FN_MFHI  = NB_FUNCTION'('h10);
  localparam logic [NB_FUNCTION-1:0] FN_MTHI  = NB_FUNCTION'('h11);
  localparam logic [NB_FUNCTION-1:0] FN_MFLO  = NB_FUNCTION'('h12);
  localparam logic [NB_FUNCTION-1:0] FN_MTLO  = NB_FUNCTION'('h13);
  localparam logic [NB_FUNCTION-1:0] FN_MULT  = NB_FUNCTION'('h18);
  localparam logic [NB_FUNCTION-1:0] FN_MULTU = NB_FUNCTION'('h19);
  localparam logic [NB_FUNCTION-1:0] FN_DIV   = NB_FUNCTION'('h1A);
  localparam logic [NB_FUNCTION-1:0] FN_DIVU  = NB_FUNCTION'('h1B);
  localparam logic [NB_FUNCTION-1:0] FN_ADDU  = NB_FUNCTION'('h21);
  localparam logic [NB_FUNCTION-1:0] FN_SUBU  = NB_FUNCTION'('h23);
  localparam logic [NB_FUNCTION-1:0] FN_AND   = NB_FUNCTION'('h24);
  localparam logic [NB_FUNCTION-1:0] FN_OR    = NB_FUNCTION'('h25);
  localparam logic [NB_FUNCTION-1:0] FN_XOR   = NB_FUNCTION'('h26);
  localparam logic [NB_FUNCTION-1:0] FN_NOR   = NB_FUNCTION'('h27);
  localparam logic [NB_FUNCTION-1:0] FN_SLT   = NB_FUNCTION'('h2A);

  // Final ALU operation codes; 0 is reserved for "no operation / unknown"
  localparam logic [NB_OP_ALU-1:0] OP_NONE = NB_OP_ALU'(0);
  localparam logic [NB_OP_ALU-1:0] OP_SLL  = NB_OP_ALU'(1);
  localparam logic [NB_OP_ALU-1:0] OP_SRL  = NB_OP_ALU'(2);
  localparam logic [NB_OP_ALU-1:0] OP_SRA  = NB_OP_ALU'(3);
  localparam logic [NB_OP_ALU-1:0] OP_SLLV = NB_OP_ALU'(4);
  localparam logic [NB_OP_ALU-1:0] OP_SRLV = NB_OP_ALU'(5);
  localparam logic [NB_OP_ALU-1:0] OP_SRAV = NB_OP_ALU'(6);
  localparam logic [NB_OP_ALU-1:0] OP_ADD  = NB_OP_ALU'(7);
  localparam logic [NB_OP_ALU-1:0] OP_SUB  = NB_OP_ALU'(8);
  localparam logic [NB_OP_ALU-1:0] OP_AND  = NB_OP_ALU'(9);
  localparam logic [NB_OP_ALU-1:0] OP_OR   = NB_OP_ALU'(10);
  localparam logic [NB_OP_ALU-1:0] OP_XOR  = NB_OP_ALU'(11);
  localparam logic [NB_OP_ALU-1:0] OP_NOR  = NB_OP_ALU'(12);
  localparam logic [NB_OP_ALU-1:0] OP_SLT  = NB_OP_ALU'(13);
  localparam logic [NB_OP_ALU-1:0] OP_LUI  = NB_OP_ALU'(14);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [NB_CNT-1:0]    cnt_q,    cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_a_q,  neg_a_d;
  logic                 neg_b_q,  neg_b_d;
  logic                 dbz_q,    dbz_d;
  logic [NB_DATA-1:0]   b_q,      b_d;     // divisor / multiplicand magnitude
  logic [NB_DATA-1:0]   acc_q,    acc_d;   // remainder / product upper half
  logic [NB_DATA-1:0]   low_q,    low_d;   // quotient / product lower half
  logic [NB_DATA-1:0]   hi_q,     hi_d;
  logic [NB_DATA-1:0]   lo_q,     lo_d;

  logic [NB_OP_ALU-1:0] w_alu_op;
  logic                 w_rtype;
  logic                 w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic                 w_is_muldiv, w_is_div, w_is_signed, w_start;
  logic [NB_DATA:0]     w_mul_sum;
  logic [NB_DATA:0]     w_div_shift;
  logic                 w_div_ge;
  logic [NB_DATA-1:0]   w_div_diff;
  logic [2*NB_DATA-1:0] w_prod, w_prod_fix;
  logic [NB_DATA-1:0]   w_res_hi, w_res_lo;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_alu_op = OP_NONE;
    case (bus.i_alu_op)
      ALUOP_RTYPE: begin
        case (bus.i_function)
          FN_SLL:  w_alu_op = OP_SLL;
          FN_SRL:  w_alu_op = OP_SRL;
          FN_SRA:  w_alu_op = OP_SRA;
          FN_SLLV: w_alu_op = OP_SLLV;
          FN_SRLV: w_alu_op = OP_SRLV;
          FN_SRAV: w_alu_op = OP_SRAV;
          FN_ADDU: w_alu_op = OP_ADD;
          FN_SUBU: w_alu_op = OP_SUB;
          FN_AND:  w_alu_op = OP_AND;
          FN_OR:   w_alu_op = OP_OR;
          FN_XOR:  w_alu_op = OP_XOR;
          FN_NOR:  w_alu_op = OP_NOR;
          FN_SLT:  w_alu_op = OP_SLT;
          default: w_alu_op = OP_NONE;
        endcase
      end
      ALUOP_ADD: w_alu_op = OP_ADD;
      ALUOP_AND: w_alu_op = OP_AND;
      ALUOP_OR:  w_alu_op = OP_OR;
      ALUOP_XOR: w_alu_op = OP_XOR;
      ALUOP_LUI: w_alu_op = OP_LUI;
      ALUOP_SLT: w_alu_op = OP_SLT;
      default:   w_alu_op = OP_NONE;
    endcase
  end

  assign w_rtype     = bus.i_valid && (bus.i_alu_op == ALUOP_RTYPE);
  assign w_is_mfhi   = w_rtype && (bus.i_function == FN_MFHI);
  assign w_is_mflo   = w_rtype && (bus.i_function == FN_MFLO);
  assign w_is_mthi   = w_rtype && (bus.i_function == FN_MTHI);
  assign w_is_mtlo   = w_rtype && (bus.i_function == FN_MTLO);
  assign w_is_div    = (bus.i_function == FN_DIV)  || (bus.i_function == FN_DIVU);
  assign w_is_signed = (bus.i_function == FN_MULT) || (bus.i_function == FN_DIV);
  assign w_is_muldiv = w_rtype && (w_is_div || (bus.i_function == FN_MULT) ||
                                   (bus.i_function == FN_MULTU));
  // Nothing may start while reset is held, so reset never leaves a stall up.
  assign w_start     = w_is_muldiv && !i_reset && (state_q == ST_IDLE);

  // --------------------------------------------------------- iteration step
  // Shift-add multiply: {acc,low} holds the partial product with the
  // multiplier consumed from low[0]; each step adds and shifts right.
  assign w_mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, b_q} : {(NB_DATA+1){1'b0}});
  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract when it fits. The difference always fits NB_DATA bits when kept.
  assign w_div_shift = {acc_q, low_q[NB_DATA-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, b_q});
  assign w_div_diff  = w_div_shift[NB_DATA-1:0] - b_q;

  // ------------------------------------------------------ sign correction
  assign w_prod     = {acc_q, low_q};
  assign w_prod_fix = (neg_a_q ^ neg_b_q) ? ({(2*NB_DATA){1'b0}} - w_prod) : w_prod;

  always_comb begin
    if (is_div_q) begin
      // A zero divisor leaves the dividend magnitude in acc, so the normal
      // remainder correction already yields the original dividend.
      w_res_hi = neg_a_q ? ({NB_DATA{1'b0}} - acc_q) : acc_q;
      if (dbz_q)
        w_res_lo = {NB_DATA{1'b1}};
      else
        w_res_lo = (neg_a_q ^ neg_b_q) ? ({NB_DATA{1'b0}} - low_q) : low_q;
    end else begin
      w_res_hi = w_prod_fix[2*NB_DATA-1:NB_DATA];
      w_res_lo = w_prod_fix[NB_DATA-1:0];
    end
  end

  // -------------------------------------------------------------- FSM next
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dbz_d    = dbz_q;
    b_d      = b_q;
    acc_d    = acc_q;
    low_d    = low_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          is_div_d = w_is_div;
          neg_a_d  = w_is_signed && bus.i_rs_data[NB_DATA-1];
          neg_b_d  = w_is_signed && bus.i_rt_data[NB_DATA-1];
          dbz_d    = (bus.i_rt_data == {NB_DATA{1'b0}});
          low_d    = (w_is_signed && bus.i_rs_data[NB_DATA-1]) ?
                     ({NB_DATA{1'b0}} - bus.i_rs_data) : bus.i_rs_data;
          b_d      = (w_is_signed && bus.i_rt_data[NB_DATA-1]) ?
                     ({NB_DATA{1'b0}} - bus.i_rt_data) : bus.i_rt_data;
          acc_d    = {NB_DATA{1'b0}};
          cnt_d    = NB_CNT'(NB_DATA);
          state_d  = ST_BUSY;
        end else if (w_is_mthi) begin
          hi_d = bus.i_rs_data;
        end else if (w_is_mtlo) begin
          lo_d = bus.i_rs_data;
        end
      end
      ST_BUSY: begin
        if (is_div_q) begin
          acc_d = w_div_ge ? w_div_diff : w_div_shift[NB_DATA-1:0];
          low_d = {low_q[NB_DATA-2:0], w_div_ge};
        end else begin
          acc_d = w_mul_sum[NB_DATA:1];
          low_d = {w_mul_sum[0], low_q[NB_DATA-1:1]};
        end
        cnt_d = cnt_q - NB_CNT'(1);
        if (cnt_q == NB_CNT'(1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        // The mul/div still sitting in EX is retired here, never restarted.
        hi_d    = w_res_hi;
        lo_d    = w_res_lo;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dbz_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dbz_q    <= dbz_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    bus.o_mdu_sel    = 1'b0;
    bus.o_mdu_result = '0;
    if (w_is_mfhi || w_is_mflo) begin
      if (state_q == ST_IDLE) begin
        bus.o_mdu_sel    = 1'b1;
        bus.o_mdu_result = w_is_mfhi ? hi_q : lo_q;
      end else if (state_q == ST_DONE) begin
        // Forward the value being written this cycle.
        bus.o_mdu_sel    = 1'b1;
        bus.o_mdu_result = w_is_mfhi ? w_res_hi : w_res_lo;
      end
    end
  end

  // BUSY stalls unconditionally, which also holds any HI/LO access behind it.
  assign bus.o_stall       = w_start || (state_q == ST_BUSY);
  assign bus.o_alu_op      = w_alu_op;
  assign bus.o_hi          = hi_q;
  assign bus.o_lo          = lo_q;
  assign bus.o_div_by_zero = (state_q == ST_DONE) && is_div_q && dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu_control
// Description : Directed self-checking bench for alu_mdu_control. Mul/div
//               expectations are queued when an operation is issued and
//               popped when the unit reaches its DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_control;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  alu_mdu_control_if bus_if ();

  alu_mdu_control dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model using the simulator's own arithmetic.
  function automatic exp_t model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    e  = '0;
    sa = a;
    sb = b;
    case (fn)
      6'h18: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      6'h19: begin p = {32'b0, a} * {32'b0, b};             e.hi = p[63:32]; e.lo = p[31:0]; end
      6'h1A, 6'h1B: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (fn == 6'h1A) begin
          e.lo = sa / sb; e.hi = sa % sb;
        end else begin
          e.lo = a / b;   e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    bus_if.i_valid    = v;
    bus_if.i_alu_op   = op;
    bus_if.i_function = fn;
    bus_if.i_rs_data  = rs;
    bus_if.i_rt_data  = rt;
  endtask

  task automatic alu_chk(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [3:0] exp);
    @(posedge clk); #1;
    drive(1'b1, op, fn, $urandom, $urandom);
    #2;
    chk({tag, "_op"}, 64'(bus_if.o_alu_op), 64'(exp));
    chk({tag, "_stall"}, 64'(bus_if.o_stall), 64'd0);
  endtask

  // Issue one mul/div, measure the stall run, check the DONE cycle and HI/LO.
  task automatic run_muldiv(input string tag, input logic [5:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input exp_t e_push, input bit mflo_after);
    int   n;
    exp_t e;
    sb_q.push_back(e_push);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, fn, a, b);
    #2;
    chk({tag, "_stall_start"}, 64'(bus_if.o_stall), 64'd1);
    n = 0;
    while (bus_if.o_stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (mflo_after && n == 1) drive(1'b1, 3'd0, 6'h12, 32'd0, 32'd0);
      #2;
    end
    chk({tag, "_stall_len"}, 64'(n), 64'd33);
    e = sb_q.pop_front();
    chk({tag, "_dbz_done"}, 64'(bus_if.o_div_by_zero), 64'(e.dbz));
    if (mflo_after) begin
      chk({tag, "_mdu_sel"}, 64'(bus_if.o_mdu_sel), 64'd1);
      chk({tag, "_mdu_fwd"}, 64'(bus_if.o_mdu_result), 64'(e.lo));
    end
    drive(1'b0, 3'd0, 6'h00, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_hi"}, 64'(bus_if.o_hi), 64'(e.hi));
    chk({tag, "_lo"}, 64'(bus_if.o_lo), 64'(e.lo));
    chk({tag, "_dbz_after"}, 64'(bus_if.o_div_by_zero), 64'd0);
    chk({tag, "_stall_after"}, 64'(bus_if.o_stall), 64'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    drive(1'b0, 3'd0, 6'h00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(bus_if.o_stall), 64'd0);
    chk("rst_hi", 64'(bus_if.o_hi), 64'd0);
    chk("rst_lo", 64'(bus_if.o_lo), 64'd0);
    chk("rst_dbz", 64'(bus_if.o_div_by_zero), 64'd0);
    chk("rst_sel", 64'(bus_if.o_mdu_sel), 64'd0);
    rst = 1'b0;

    // ALU operation decode: R-type functions then immediate ALUops
    alu_chk("sll",  3'd0, 6'h00, 4'd1);
    alu_chk("srl",  3'd0, 6'h02, 4'd2);
    alu_chk("sra",  3'd0, 6'h03, 4'd3);
    alu_chk("sllv", 3'd0, 6'h04, 4'd4);
    alu_chk("srlv", 3'd0, 6'h06, 4'd5);
    alu_chk("srav", 3'd0, 6'h07, 4'd6);
    alu_chk("addu", 3'd0, 6'h21, 4'd7);
    alu_chk("subu", 3'd0, 6'h23, 4'd8);
    alu_chk("and",  3'd0, 6'h24, 4'd9);
    alu_chk("or",   3'd0, 6'h25, 4'd10);
    alu_chk("xor",  3'd0, 6'h26, 4'd11);
    alu_chk("nor",  3'd0, 6'h27, 4'd12);
    alu_chk("slt",  3'd0, 6'h2A, 4'd13);
    alu_chk("addi", 3'd1, 6'h2A, 4'd7);
    alu_chk("andi", 3'd2, 6'h2A, 4'd9);
    alu_chk("ori",  3'd3, 6'h2A, 4'd10);
    alu_chk("xori", 3'd4, 6'h2A, 4'd11);
    alu_chk("lui",  3'd5, 6'h2A, 4'd14);
    alu_chk("slti", 3'd6, 6'h2A, 4'd13);
    alu_chk("unk_op",  3'd7, 6'h21, 4'd0);
    alu_chk("unk_fn",  3'd0, 6'h01, 4'd0);
    alu_chk("mfhi_op", 3'd0, 6'h10, 4'd0);

    // Mul/div functions without i_valid must not stall
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 6'h18, 32'd3, 32'd4);
    #2;
    chk("mult_novalid_stall", 64'(bus_if.o_stall), 64'd0);
    chk("mult_alu_op", 64'(bus_if.o_alu_op), 64'd0);

    // MTHI / MTLO / MFHI / MFLO in IDLE
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h11, 32'h0000_00AA, 32'd0);
    #2;
    chk("mthi_stall", 64'(bus_if.o_stall), 64'd0);
    chk("mthi_hi_before", 64'(bus_if.o_hi), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h13, 32'h0000_0055, 32'd0);
    #2;
    chk("mthi_hi_after", 64'(bus_if.o_hi), 64'h0000_00AA);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h10, 32'd0, 32'd0);
    #2;
    chk("mtlo_lo_after", 64'(bus_if.o_lo), 64'h0000_0055);
    chk("mfhi_sel", 64'(bus_if.o_mdu_sel), 64'd1);
    chk("mfhi_result", 64'(bus_if.o_mdu_result), 64'h0000_00AA);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h12, 32'd0, 32'd0);
    #2;
    chk("mflo_result", 64'(bus_if.o_mdu_result), 64'h0000_0055);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 6'h12, 32'd0, 32'd0);
    #2;
    chk("mflo_novalid_sel", 64'(bus_if.o_mdu_sel), 64'd0);

    // Directed mul/div vectors (literal expectations) and model-driven ones
    e = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFB, dbz: 1'b0};
    run_muldiv("mult_m1x5", 6'h18, 32'hFFFF_FFFF, 32'd5, e, 1'b0);
    e = '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0};
    run_muldiv("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, 1'b0);
    e = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0};
    run_muldiv("div_m7d2", 6'h1A, 32'hFFFF_FFF9, 32'd2, e, 1'b0);
    e = '{hi: 32'h0000_0007, lo: 32'hFFFF_FFFF, dbz: 1'b1};
    run_muldiv("divu_7d0", 6'h1B, 32'd7, 32'd0, e, 1'b0);
    run_muldiv("div_m7d0",   6'h1A, 32'hFFFF_FFF9, 32'd0, model(6'h1A, 32'hFFFF_FFF9, 32'd0), 1'b0);
    run_muldiv("div_7dm2",   6'h1A, 32'd7, 32'hFFFF_FFFE, model(6'h1A, 32'd7, 32'hFFFF_FFFE), 1'b0);
    run_muldiv("divu_big",   6'h1B, 32'hDEAD_BEEF, 32'd1234, model(6'h1B, 32'hDEAD_BEEF, 32'd1234), 1'b0);
    run_muldiv("mult_negneg", 6'h18, 32'h8000_0001, 32'hFFFF_0003, model(6'h18, 32'h8000_0001, 32'hFFFF_0003), 1'b0);
    run_muldiv("multu_mix",  6'h19, 32'h1234_5678, 32'h9ABC_DEF0, model(6'h19, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);

    // MFLO arriving right behind MULT 3*4 waits and then sees the forwarded 12
    e = '{hi: 32'd0, lo: 32'd12, dbz: 1'b0};
    run_muldiv("mult_mflo", 6'h18, 32'd3, 32'd4, e, 1'b1);

    // Reset during BUSY aborts a DIV without touching HI/LO with partials
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h11, 32'h0000_00AA, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 6'h1A, 32'd100, 32'd7);
    #2;
    chk("abort_hi_pre", 64'(bus_if.o_hi), 64'h0000_00AA);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 3'd0, 6'h00, 32'd0, 32'd0);
    #2;
    chk("abort_busy_stall", 64'(bus_if.o_stall), 64'd1);
    @(posedge clk); #1;
    chk("abort_stall", 64'(bus_if.o_stall), 64'd0);
    chk("abort_hi", 64'(bus_if.o_hi), 64'd0);
    chk("abort_lo", 64'(bus_if.o_lo), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_stall", 64'(bus_if.o_stall), 64'd0);
    chk("abort_idle_lo", 64'(bus_if.o_lo), 64'd0);

    run_muldiv("post_rst_divu", 6'h1B, 32'd100, 32'd7, model(6'h1B, 32'd100, 32'd7), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
